// File: rtl/silencer_update_ctl.sv
// silencer_update_ctl: frame sequencer and settings gate in front of the silencer.
// Each UPDATE reads DEPTH (intensity, phase) entries from the drive-data source.
// It streams them to the silencer as one contiguous DIN_VALID burst, then waits for
// the matching DOUT_VALID burst. Silencer settings change only between frames.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   UPDATE            single-cycle frame request
//   SETTINGS_IN/REQ   settings from control registers and adopt strobe
//   SETTINGS_OUT      settings presented to the silencer
//   SRC_ADDR          source read address (source has 1-cycle read latency)
//   SRC_INTENSITY/PHASE source read data
//   DIN_VALID, INTENSITY, PHASE  stream into the silencer
//   DOUT_VALID        silencer output strobe
//   BUSY              FSM not in IDLE
//   OVERRUN, OVERRUN_CNT  dropped-update pulse and saturating count

package params;
    localparam logic [7:0] SILENCER_MODE_FIXED_COMPLETION_STEPS = 8'd0;
    localparam logic [7:0] SILENCER_MODE_FIXED_UPDATE_RATE      = 8'd1;
endpackage

package settings;
    typedef struct packed {
        logic [7:0]  MODE;
        logic [15:0] UPDATE_RATE_INTENSITY;
        logic [15:0] UPDATE_RATE_PHASE;
        logic [15:0] COMPLETION_STEPS_INTENSITY;
        logic [15:0] COMPLETION_STEPS_PHASE;
    } silencer_settings_t;
endpackage

module silencer_update_ctl #(
    parameter int unsigned DEPTH = 249,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          UPDATE,
    input  settings::silencer_settings_t  SETTINGS_IN,
    input  logic                          SETTINGS_REQ,
    output settings::silencer_settings_t  SETTINGS_OUT,
    output logic [AW-1:0]                 SRC_ADDR,
    input  logic [15:0]                   SRC_INTENSITY,
    input  logic [7:0]                    SRC_PHASE,
    output logic                          DIN_VALID,
    output logic [15:0]                   INTENSITY,
    output logic [7:0]                    PHASE,
    input  logic                          DOUT_VALID,
    output logic                          BUSY,
    output logic                          OVERRUN,
    output logic [15:0]                   OVERRUN_CNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam settings::silencer_settings_t SETTINGS_RST = '{
        MODE:                       params::SILENCER_MODE_FIXED_COMPLETION_STEPS,
        UPDATE_RATE_INTENSITY:      16'd0,
        UPDATE_RATE_PHASE:          16'd0,
        COMPLETION_STEPS_INTENSITY: 16'd1,
        COMPLETION_STEPS_PHASE:     16'd1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic                         upd_pend_q, upd_pend_d;
    logic                         set_pend_q, set_pend_d;
    settings::silencer_settings_t shadow_q, shadow_d;
    settings::silencer_settings_t settings_q, settings_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic                         din_valid_q, din_valid_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;
    logic [15:0]                  ovr_cnt_q, ovr_cnt_d;
    logic [CW-1:0]                out_cnt_q, out_cnt_d;

    logic [CW-1:0]                out_cnt_nxt;
    logic                         issue_entry;

    // In fixed-completion-steps mode a zero step count would stall the silencer.
    function automatic settings::silencer_settings_t sanitize(
        input settings::silencer_settings_t s
    );
        settings::silencer_settings_t r;
        r = s;
        if (s.MODE == params::SILENCER_MODE_FIXED_COMPLETION_STEPS) begin
            if (s.COMPLETION_STEPS_INTENSITY == 16'd0) r.COMPLETION_STEPS_INTENSITY = 16'd1;
            if (s.COMPLETION_STEPS_PHASE == 16'd0)     r.COMPLETION_STEPS_PHASE = 16'd1;
        end
        return r;
    endfunction

    // Output-beat count including this cycle's DOUT_VALID, held at DEPTH.
    assign out_cnt_nxt = (DOUT_VALID && (out_cnt_q != CW'(DEPTH))) ? out_cnt_q + CW'(1)
                                                                  : out_cnt_q;
    assign issue_entry = (state_d == ISSUE) && (state_q != ISSUE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; UPDATE and SETTINGS_REQ act in the same cycle they arrive in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (upd_pend_q || UPDATE) begin
                    state_d = (set_pend_q || SETTINGS_REQ) ? APPLY : ISSUE;
                end
            end
            APPLY: state_d = ISSUE;
            ISSUE: begin
                if (addr_q == AW'(DEPTH - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_cnt_nxt == CW'(DEPTH)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        upd_pend_d  = upd_pend_q;
        set_pend_d  = set_pend_q;
        shadow_d    = shadow_q;
        settings_d  = settings_q;
        addr_d      = '0;
        din_valid_d = (state_q == ISSUE);
        busy_d      = (state_d != IDLE);
        overrun_d   = 1'b0;
        ovr_cnt_d   = ovr_cnt_q;
        out_cnt_d   = out_cnt_q;

        // Update flag: IDLE consumes it (or holds it across APPLY); leaving APPLY
        // consumes it but an UPDATE in that cycle is kept for the next frame.
        case (state_q)
            IDLE:    upd_pend_d = (state_d == APPLY);
            APPLY:   upd_pend_d = UPDATE;
            default: upd_pend_d = upd_pend_q || UPDATE;
        endcase
        overrun_d = UPDATE && upd_pend_q && (state_q != APPLY);
        if (overrun_d && (ovr_cnt_q != 16'hFFFF)) ovr_cnt_d = ovr_cnt_q + 16'd1;

        // Shadow is last-wins; a request coinciding with APPLY stays pending.
        if (SETTINGS_REQ) begin
            shadow_d   = SETTINGS_IN;
            set_pend_d = 1'b1;
        end else if (state_q == APPLY) begin
            set_pend_d = 1'b0;
        end
        if (state_q == APPLY) settings_d = sanitize(shadow_q);

        if ((state_q == ISSUE) && (state_d == ISSUE)) addr_d = addr_q + AW'(1);

        if (issue_entry) begin
            out_cnt_d = '0;
        end else if ((state_q == ISSUE) || (state_q == DRAIN)) begin
            out_cnt_d = out_cnt_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_pend_q  <= 1'b0;
            set_pend_q  <= 1'b0;
            shadow_q    <= SETTINGS_RST;
            settings_q  <= SETTINGS_RST;
            addr_q      <= '0;
            din_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            upd_pend_q  <= upd_pend_d;
            set_pend_q  <= set_pend_d;
            shadow_q    <= shadow_d;
            settings_q  <= settings_d;
            addr_q      <= addr_d;
            din_valid_q <= din_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // Source data is already registered by the source; forward it aligned with DIN_VALID.
    assign INTENSITY    = din_valid_q ? SRC_INTENSITY : 16'd0;
    assign PHASE        = din_valid_q ? SRC_PHASE : 8'd0;
    assign DIN_VALID    = din_valid_q;
    assign SRC_ADDR     = addr_q;
    assign SETTINGS_OUT = settings_q;
    assign BUSY         = busy_q;
    assign OVERRUN      = overrun_q;
    assign OVERRUN_CNT  = ovr_cnt_q;

endmodule

// File: tb/tb_silencer_update_ctl.sv
// Scoreboard bench for silencer_update_ctl: expected stream entries are queued when a
// frame is requested and a monitor pops/compares them on every DIN_VALID beat.
module tb_silencer_update_ctl;

    localparam int unsigned DEPTH    = 249;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned DOUT_LAT = 4;

    typedef settings::silencer_settings_t set_t;
    typedef struct packed {
        logic [15:0] inten;
        logic [7:0]  ph;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          UPDATE;
    set_t          SETTINGS_IN;
    logic          SETTINGS_REQ;
    set_t          SETTINGS_OUT;
    logic [AW-1:0] SRC_ADDR;
    logic [15:0]   SRC_INTENSITY;
    logic [7:0]    SRC_PHASE;
    logic          DIN_VALID;
    logic [15:0]   INTENSITY;
    logic [7:0]    PHASE;
    logic          DOUT_VALID;
    logic          BUSY;
    logic          OVERRUN;
    logic [15:0]   OVERRUN_CNT;

    always #5 CLK = ~CLK;

    silencer_update_ctl #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .UPDATE(UPDATE),
        .SETTINGS_IN(SETTINGS_IN), .SETTINGS_REQ(SETTINGS_REQ), .SETTINGS_OUT(SETTINGS_OUT),
        .SRC_ADDR(SRC_ADDR), .SRC_INTENSITY(SRC_INTENSITY), .SRC_PHASE(SRC_PHASE),
        .DIN_VALID(DIN_VALID), .INTENSITY(INTENSITY), .PHASE(PHASE),
        .DOUT_VALID(DOUT_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN), .OVERRUN_CNT(OVERRUN_CNT)
    );

    int pattern = 0;
    int checks  = 0;
    int errors  = 0;
    int ovr_seen = 0;
    entry_t sb[$];

    function automatic entry_t src_entry(input int pat, input int a);
        entry_t e;
        case (pat)
            0:       begin e.inten = 16'(a);                e.ph = 8'(a); end
            1:       begin e.inten = 16'(a * 257 + 3);      e.ph = 8'(255 - a); end
            2:       begin e.inten = 16'(40000 - a * 11);   e.ph = 8'(a * 7); end
            default: begin e.inten = 16'(a) ^ 16'hA5C3;     e.ph = 8'(a + 128); end
        endcase
        return e;
    endfunction

    function automatic set_t mk_set(input logic [7:0] mode, input logic [15:0] ri,
                                    input logic [15:0] rp, input logic [15:0] ci,
                                    input logic [15:0] cp);
        set_t s;
        s.MODE = mode;
        s.UPDATE_RATE_INTENSITY = ri;
        s.UPDATE_RATE_PHASE = rp;
        s.COMPLETION_STEPS_INTENSITY = ci;
        s.COMPLETION_STEPS_PHASE = cp;
        return s;
    endfunction

    // Source with 1-cycle read latency
    always @(posedge CLK) {SRC_INTENSITY, SRC_PHASE} <= src_entry(pattern, int'(SRC_ADDR));

    // Silencer stand-in: DOUT_VALID is DIN_VALID delayed; keeps running through RST
    logic [DOUT_LAT-1:0] dly = '0;
    always @(posedge CLK) dly <= {dly[DOUT_LAT-2:0], DIN_VALID};
    assign DOUT_VALID = dly[DOUT_LAT-1];

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input int pat);
        for (int i = 0; i < int'(DEPTH); i++) sb.push_back(src_entry(pat, i));
    endfunction

    // Monitor: every DIN_VALID beat consumes one scoreboard entry
    always @(negedge CLK) begin
        if (OVERRUN === 1'b1) ovr_seen++;
        if (DIN_VALID === 1'b1) begin
            check("din_expected", 96'(sb.size() != 0), 96'(1));
            if (sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                check("din_data", 96'({INTENSITY, PHASE}), 96'(e));
            end
        end
    end

    // Issues UPDATE at a negedge; returns at the negedge of the first DIN_VALID.
    task automatic start_frame(input int pat, input bit req, input set_t s,
                               input int exp_lat, input set_t exp_set);
        int n;
        pattern = pat;
        push_frame(pat);
        UPDATE = 1'b1;
        SETTINGS_REQ = req;
        SETTINGS_IN = s;
        @(negedge CLK);
        UPDATE = 1'b0;
        SETTINGS_REQ = 1'b0;
        check("busy_rise", 96'(BUSY), 96'(1));
        n = 1;
        while (DIN_VALID !== 1'b1 && n < 10) begin
            if (n == exp_lat - 1) begin
                check("settings_pre_din", 96'(SETTINGS_OUT), 96'(exp_set));
                check("src_addr_first", 96'(SRC_ADDR), 96'(0));
            end
            @(negedge CLK);
            n++;
        end
        check("din_latency", 96'(n), 96'(exp_lat));
    endtask

    // Follows a frame to its end; optional mid-frame settings request and UPDATE pulses.
    task automatic wait_end(input set_t exp_set, input int req_at, input set_t s_req,
                            input int n_upd);
        int n_dout;
        int c;
        bit set_ok;
        n_dout = 0;
        c = 0;
        set_ok = 1'b1;
        while (c < 2000) begin
            SETTINGS_REQ = (c == req_at);
            if (c == req_at) SETTINGS_IN = s_req;
            UPDATE = (c == 30 && n_upd >= 1) || (c == 60 && n_upd >= 2) ||
                     (c == 90 && n_upd >= 3);
            if (c == 30 && n_upd >= 1) push_frame(pattern);
            if (SETTINGS_OUT !== exp_set) set_ok = 1'b0;
            if (DOUT_VALID === 1'b1) n_dout++;
            if (n_dout == int'(DEPTH)) break;
            @(negedge CLK);
            c++;
        end
        check("dout_count", 96'(n_dout), 96'(DEPTH));
        @(negedge CLK);
        UPDATE = 1'b0;
        SETTINGS_REQ = 1'b0;
        check("busy_fall", 96'(BUSY), 96'(0));
        check("settings_stable", 96'(set_ok), 96'(1));
        check("sb_level", 96'(sb.size()), 96'((n_upd > 0) ? DEPTH : 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        set_t s_rst, s10, s20, s05, s15;
        int k;
        s_rst = mk_set(params::SILENCER_MODE_FIXED_COMPLETION_STEPS, 16'd0, 16'd0, 16'd1, 16'd1);
        s10   = mk_set(params::SILENCER_MODE_FIXED_COMPLETION_STEPS, 16'd256, 16'd256, 16'd10, 16'd10);
        s20   = mk_set(params::SILENCER_MODE_FIXED_COMPLETION_STEPS, 16'd256, 16'd256, 16'd20, 16'd20);
        s05   = mk_set(params::SILENCER_MODE_FIXED_COMPLETION_STEPS, 16'd300, 16'd400, 16'd0, 16'd5);
        s15   = mk_set(params::SILENCER_MODE_FIXED_COMPLETION_STEPS, 16'd300, 16'd400, 16'd1, 16'd5);

        RST = 1'b1;
        UPDATE = 1'b0;
        SETTINGS_REQ = 1'b0;
        SETTINGS_IN = '0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 96'(BUSY), 96'(0));
        check("rst_din", 96'(DIN_VALID), 96'(0));
        check("rst_intensity", 96'(INTENSITY), 96'(0));
        check("rst_phase", 96'(PHASE), 96'(0));
        check("rst_addr", 96'(SRC_ADDR), 96'(0));
        check("rst_overrun", 96'(OVERRUN), 96'(0));
        check("rst_ovr_cnt", 96'(OVERRUN_CNT), 96'(0));
        check("rst_settings", 96'(SETTINGS_OUT), 96'(s_rst));
        RST = 1'b0;
        @(negedge CLK);

        // Plain frame from idle
        start_frame(0, 1'b0, '0, 2, s_rst);
        wait_end(s_rst, -1, '0, 0);

        // Settings together with UPDATE right after reset
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        start_frame(1, 1'b1, s10, 3, s10);
        wait_end(s10, -1, '0, 0);

        // Mid-frame settings request waits for the next frame
        start_frame(2, 1'b0, '0, 2, s10);
        wait_end(s10, 50, s20, 0);
        repeat (3) @(negedge CLK);
        check("settings_held_idle", 96'(SETTINGS_OUT), 96'(s10));
        start_frame(0, 1'b0, '0, 3, s20);
        wait_end(s20, -1, '0, 0);

        // Three UPDATEs in one frame: one follow-on frame, two overruns
        start_frame(1, 1'b0, '0, 2, s20);
        wait_end(s20, -1, '0, 3);
        check("overrun_pulses", 96'(ovr_seen), 96'(2));
        check("overrun_cnt", 96'(OVERRUN_CNT), 96'(2));
        @(negedge CLK);
        check("followon_busy", 96'(BUSY), 96'(1));
        k = 0;
        while (DIN_VALID !== 1'b1 && k < 10) begin
            @(negedge CLK);
            k++;
        end
        check("followon_latency", 96'(k), 96'(1));
        wait_end(s20, -1, '0, 0);
        repeat (20) @(negedge CLK);
        check("no_extra_frame", 96'(BUSY), 96'(0));
        check("overrun_pulses_final", 96'(ovr_seen), 96'(2));

        // Zero completion steps in fixed-steps mode are forced to 1
        SETTINGS_IN = s05;
        SETTINGS_REQ = 1'b1;
        @(negedge CLK);
        SETTINGS_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        start_frame(2, 1'b0, '0, 3, s15);
        wait_end(s15, -1, '0, 0);

        // Reset at the 100th DIN_VALID, then a fresh full frame
        start_frame(3, 1'b0, '0, 2, s15);
        k = 1;
        while (k < 100) begin
            @(negedge CLK);
            if (DIN_VALID === 1'b1) k++;
            else break;
        end
        check("din_contiguous_100", 96'(k), 96'(100));
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_din", 96'(DIN_VALID), 96'(0));
        check("mid_rst_busy", 96'(BUSY), 96'(0));
        check("mid_rst_ovr_cnt", 96'(OVERRUN_CNT), 96'(0));
        check("mid_rst_settings", 96'(SETTINGS_OUT), 96'(s_rst));
        check("mid_rst_addr", 96'(SRC_ADDR), 96'(0));
        RST = 1'b0;
        sb.delete();
        repeat (10) @(negedge CLK);
        check("post_rst_idle", 96'(BUSY), 96'(0));
        start_frame(0, 1'b0, '0, 2, s_rst);
        wait_end(s_rst, -1, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/silencer_update_ctl.md
# silencer_update_ctl

Frame sequencer and settings gate in front of `silencer`. On each `UPDATE` pulse it reads `DEPTH` drive entries (intensity, phase) from the upstream drive-data source and streams them into `silencer` as one contiguous `DIN_VALID` burst. It waits for the matching `DOUT_VALID` burst before accepting the next frame. New silencer settings from the control registers are adopted only between frames, so `SILENCER_SETTINGS` never changes inside a frame.

## Interface
Parameters:
- `DEPTH`, 249, number of transducers per frame.
- `AW`, `$clog2(DEPTH)`, source address width (derived, not overridden).

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: reset, synchronous, active-high.
- `UPDATE` in 1: single-cycle frame request.
- `SETTINGS_IN` in `settings::silencer_settings_t`: settings from the control registers.
- `SETTINGS_REQ` in 1: single-cycle request to adopt `SETTINGS_IN`.
- `SETTINGS_OUT` out `settings::silencer_settings_t`: drives `silencer.SILENCER_SETTINGS`.
- `SRC_ADDR` out `AW`: read address to the source; the source has a fixed 1-cycle read latency.
- `SRC_INTENSITY` in 16: source read data.
- `SRC_PHASE` in 8: source read data.
- `DIN_VALID` out 1: to `silencer`.
- `INTENSITY` out 16: to `silencer`.
- `PHASE` out 8: to `silencer`.
- `DOUT_VALID` in 1: from `silencer`.
- `BUSY` out 1: high whenever the FSM is not in IDLE.
- `OVERRUN` out 1: one-cycle pulse when an `UPDATE` is dropped.
- `OVERRUN_CNT` out 16: saturating count of dropped updates.

## Operation
- FSM states: IDLE, APPLY, ISSUE, DRAIN.
- IDLE, update pending, settings pending: go to APPLY. Update pending, no settings pending: go to ISSUE. Otherwise stay in IDLE.
- APPLY (1 cycle):
  - `SETTINGS_OUT <= shadow`.
  - If `MODE == params::SILENCER_MODE_FIXED_COMPLETION_STEPS`, any completion-steps field equal to 0 is replaced by 1.
  - Clear settings-pending, then go to ISSUE.
- ISSUE:
  - Clear update-pending on entry.
  - `SRC_ADDR` counts 0 to DEPTH-1, one per cycle.
  - One cycle later, `DIN_VALID=1` with `INTENSITY`/`PHASE` equal to the registered source data for that address.
  - After address DEPTH-1 is issued, go to DRAIN.
- DRAIN: wait until the output counter reaches DEPTH, then go to IDLE.
- Output counter: counts `DOUT_VALID`-high cycles during both ISSUE and DRAIN, and is cleared on ISSUE entry. `DOUT_VALID` outside ISSUE/DRAIN is ignored.
- Update pending (1-deep flag):
  - Set by `UPDATE` in any state.
  - If `UPDATE` arrives while the flag is already set: `OVERRUN` pulses and `OVERRUN_CNT` increments, saturating at 0xFFFF. The flag stays set.
  - `UPDATE` in the same cycle as ISSUE entry sets the flag for the next frame.
- Settings pending:
  - `SETTINGS_REQ` copies `SETTINGS_IN` to the shadow register and sets the flag.
  - A later request before APPLY overwrites the shadow (last wins).
  - A `SETTINGS_REQ` in the same cycle as `UPDATE` in IDLE is applied before that frame.
  - A `SETTINGS_REQ` during ISSUE or DRAIN waits for the next frame.
- `DIN_VALID` is low in every cycle outside the DEPTH-cycle burst.

## Timing
- Reset values:
  - FSM IDLE; `BUSY=0`, `DIN_VALID=0`, `INTENSITY=0`, `PHASE=0`, `SRC_ADDR=0`, `OVERRUN=0`, `OVERRUN_CNT=0`.
  - Both pending flags cleared.
  - `SETTINGS_OUT`: `MODE = params::SILENCER_MODE_FIXED_COMPLETION_STEPS`, both completion steps = 1, all other fields 0.
- `UPDATE` at cycle t, FSM in IDLE, no settings pending:
  - t+1: ISSUE, `SRC_ADDR=0`.
  - t+2: first `DIN_VALID`.
  - t+1+DEPTH: last `DIN_VALID`.
  - `BUSY` rises at t+1.
- With settings pending, every event above is one cycle later; the new `SETTINGS_OUT` is visible at t+2.
- Frame end: the cycle after the DEPTH-th `DOUT_VALID`, the FSM is in IDLE and `BUSY=0`. A pending update enters ISSUE on the following cycle, giving a minimum gap of 1 IDLE cycle between bursts.
- `SETTINGS_OUT` is constant from APPLY exit (or ISSUE entry) until return to IDLE.
- `RST` mid-frame: all reset values apply at the next edge, and `DIN_VALID` is low from that edge. Any `DOUT_VALID` still arriving from `silencer` is ignored.

## Test plan
- Idle start, DEPTH=249, source entry i = (i, i&0xFF); one `UPDATE`.
  - Required: exactly 249 `DIN_VALID` cycles starting 2 cycles after `UPDATE`, data matching each address in order.
  - `BUSY` falls 1 cycle after the 249th `DOUT_VALID`.
- `SETTINGS_REQ` with steps (10,10) together with `UPDATE` from reset.
  - Required: `SETTINGS_OUT` shows (10,10) one cycle before the first `DIN_VALID`.
  - Through `silencer` with all-(128,128) data after a (10,10) frame, the first output is intensity 22, phase 21.
- `SETTINGS_REQ` with steps (20,20) mid-frame.
  - Required: `SETTINGS_OUT` unchanged until the frame ends.
  - Required: the value applied at the next `UPDATE`.
- Three `UPDATE`s during one frame.
  - Required: exactly one follow-on frame, `OVERRUN` pulsed twice, `OVERRUN_CNT=2`.
- `SETTINGS_REQ` with fixed-completion-steps mode, steps (0,5), then `UPDATE`.
  - Required: `SETTINGS_OUT` steps = (1,5).
- `RST` asserted at the 100th `DIN_VALID`.
  - Required: next cycle `DIN_VALID=0`, `BUSY=0`, `OVERRUN_CNT=0`, `SETTINGS_OUT` at reset values.
  - Required: a fresh `UPDATE` then produces a full 249-entry frame.
